// File: rtl/stream_merge_pkg.sv
// stream_merge_pkg: shared constants and helpers for the round-robin stream merge.
package stream_merge_pkg;
  localparam int QDEPTH = 2;
  function automatic int srcw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/stream_merge_rr_arb.sv
// stream_merge_rr_arb: one-hot round-robin grant with a rotating priority pointer.
module stream_merge_rr_arb
  import stream_merge_pkg::*;
#(
  parameter  int nports = 2,
  localparam int SRCW   = srcw(nports)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [nports-1:0] req,
  input  logic              en,
  output logic [nports-1:0] grant,
  output logic [SRCW-1:0]   grant_idx
);
  logic [SRCW-1:0] p_q, p_d;
  int best_d, best_i, d;
  // Winner is the requester at the smallest wrap-around distance from the pointer.
  always_comb begin
    best_d = nports;
    best_i = 0;
    d      = 0;
    for (int j = 0; j < nports; j++) begin
      d = (j >= int'(p_q)) ? j - int'(p_q) : j + nports - int'(p_q);
      if (req[j] && d < best_d) begin
        best_d = d;
        best_i = j;
      end
    end
    for (int j = 0; j < nports; j++) grant[j] = (best_d < nports) && (best_i == j);
    grant_idx = SRCW'(best_i);
    p_d       = en ? SRCW'((best_i + 1) % nports) : p_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) p_q <= '0;
    else        p_q <= p_d;
  end
endmodule

// File: rtl/stream_merge_rr.sv
// stream_merge_rr: N:1 round-robin merge of val/rdy streams into a 2-entry registered queue,
// tagging each message with its source port.
module stream_merge_rr
  import stream_merge_pkg::*;
#(
  parameter  int nports = 2,
  parameter  int nbits  = 32,
  localparam int SRCW   = srcw(nports)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [nbits-1:0] istream_msg [nports],
  input  logic             istream_val [nports],
  output logic             istream_rdy [nports],
  output logic [nbits-1:0] ostream_msg,
  output logic [SRCW-1:0]  ostream_src,
  output logic             ostream_val,
  input  logic             ostream_rdy
);
  typedef struct packed {
    logic [SRCW-1:0]  src;
    logic [nbits-1:0] msg;
  } entry_t;
  entry_t          q_q [QDEPTH];
  logic            head_q, tail_q;
  logic [1:0]      cnt_q, cnt_d;
  logic [nports-1:0] req, grant;
  logic [SRCW-1:0] gidx;
  logic [nbits-1:0] in_msg;
  logic            full, enq, deq;
  stream_merge_rr_arb #(.nports(nports)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .en        (enq),
    .grant     (grant),
    .grant_idx (gidx)
  );
  // Full queue blocks every input, even when the head drains this cycle.
  always_comb begin
    full   = cnt_q == 2'd2;
    in_msg = '0;
    for (int i = 0; i < nports; i++) begin
      req[i]         = istream_val[i];
      istream_rdy[i] = grant[i] && !full;
      in_msg         = in_msg | (grant[i] ? istream_msg[i] : '0);
    end
    enq   = |grant && !full;
    deq   = ostream_val && ostream_rdy;
    cnt_d = cnt_q + 2'(enq) - 2'(deq);
  end
  assign ostream_val = cnt_q != 2'd0;
  assign ostream_msg = q_q[head_q].msg;
  assign ostream_src = q_q[head_q].src;
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q[0] <= '0;
      q_q[1] <= '0;
      head_q <= 1'b0;
      tail_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (enq) begin
        q_q[tail_q] <= '{src: gidx, msg: in_msg};
        tail_q      <= ~tail_q;
      end
      if (deq) head_q <= ~head_q;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_stream_merge_rr.sv
// tb_stream_merge_rr: table-driven and scoreboard checks of the 4-port round-robin merge.
module tb_stream_merge_rr;
  localparam int NP = 4;
  localparam int NB = 32;
  localparam int SW = 2;
  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] imsg [NP];
  logic          ival [NP];
  logic          irdy [NP];
  logic [NB-1:0] omsg;
  logic [SW-1:0] osrc;
  logic          oval, ordy;
  always #5 clk = ~clk;
  stream_merge_rr #(.nports(NP), .nbits(NB)) dut (
    .clk         (clk),
    .reset       (reset),
    .istream_msg (imsg),
    .istream_val (ival),
    .istream_rdy (irdy),
    .ostream_msg (omsg),
    .ostream_src (osrc),
    .ostream_val (oval),
    .ostream_rdy (ordy)
  );
  typedef struct packed {
    logic [SW-1:0] src;
    logic [NB-1:0] msg;
  } ent_t;
  typedef struct {
    bit            rst;
    logic [NP-1:0] val;
    bit            ordy;
    logic [NP-1:0] erdy;
    bit            eoval;
    logic [SW-1:0] esrc;
  } vec_t;
  ent_t sb[$];
  vec_t tbl[20];
  int   m_p = 0;
  bit   chk = 0;
  int   tests = 0, fails = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask
  // One clock: check outputs against the model at negedge, advance the model at posedge.
  task automatic cycle(input bit t, input logic [NP-1:0] erdy, input bit eoval, input logic [SW-1:0] esrc);
    int g;
    bit enq, deq;
    logic [NP-1:0] er, rv;
    @(negedge clk);
    g = -1;
    for (int i = 0; i < NP; i++) if (g < 0 && ival[(m_p + i) % NP]) g = (m_p + i) % NP;
    enq = g >= 0 && sb.size() < 2;
    er  = '0;
    if (enq) er[g] = 1'b1;
    for (int i = 0; i < NP; i++) rv[i] = irdy[i];
    if (chk) begin
      check("rdy", rv, er);
      check("oval", oval, sb.size() != 0);
      if (sb.size() != 0) begin
        check("omsg", omsg, sb[0].msg);
        check("osrc", osrc, sb[0].src);
      end
    end
    if (t) begin
      check("tbl_rdy", rv, erdy);
      check("tbl_oval", oval, eoval);
      if (eoval) check("tbl_src", osrc, esrc);
    end
    deq = sb.size() != 0 && ordy;
    @(posedge clk);
    if (!reset) begin
      sb.delete();
      m_p = 0;
      chk = 1;
    end else begin
      if (deq) void'(sb.pop_front());
      if (enq) begin
        sb.push_back('{src: SW'(g), msg: imsg[g]});
        m_p = (g + 1) % NP;
      end
    end
    #1;
  endtask
  initial begin
    tbl[0]  = '{1, 4'hF, 1'b0, 4'b0001, 1'b0, 2'd0};
    tbl[1]  = '{1, 4'hF, 1'b0, 4'b0010, 1'b1, 2'd0};
    tbl[2]  = '{1, 4'hF, 1'b1, 4'b0000, 1'b1, 2'd0};
    tbl[3]  = '{1, 4'hF, 1'b0, 4'b0100, 1'b1, 2'd1};
    tbl[4]  = '{1, 4'h0, 1'b1, 4'b0000, 1'b1, 2'd1};
    tbl[5]  = '{1, 4'h1, 1'b0, 4'b0001, 1'b1, 2'd2};
    tbl[6]  = '{1, 4'h0, 1'b1, 4'b0000, 1'b1, 2'd2};
    tbl[7]  = '{1, 4'h0, 1'b1, 4'b0000, 1'b1, 2'd0};
    tbl[8]  = '{1, 4'h0, 1'b1, 4'b0000, 1'b0, 2'd0};
    tbl[9]  = '{1, 4'h8, 1'b1, 4'b1000, 1'b0, 2'd0};
    tbl[10] = '{1, 4'h6, 1'b1, 4'b0010, 1'b1, 2'd3};
    tbl[11] = '{1, 4'h6, 1'b1, 4'b0100, 1'b1, 2'd1};
    tbl[12] = '{1, 4'h0, 1'b1, 4'b0000, 1'b1, 2'd2};
    tbl[13] = '{1, 4'h0, 1'b1, 4'b0000, 1'b0, 2'd0};
    tbl[14] = '{1, 4'h4, 1'b1, 4'b0100, 1'b0, 2'd0};
    tbl[15] = '{1, 4'h1, 1'b0, 4'b0001, 1'b1, 2'd2};
    tbl[16] = '{0, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd2};
    tbl[17] = '{1, 4'hF, 1'b1, 4'b0001, 1'b0, 2'd0};
    tbl[18] = '{1, 4'h0, 1'b1, 4'b0000, 1'b1, 2'd0};
    tbl[19] = '{1, 4'h0, 1'b1, 4'b0000, 1'b0, 2'd0};
    reset = 1'b0;
    ordy  = 1'b1;
    for (int i = 0; i < NP; i++) begin
      ival[i] = 1'b1;
      imsg[i] = NB'(32'h100 + i);
    end
    cycle(0, '0, 0, '0);
    cycle(0, '0, 0, '0);
    check("rst_oval", oval, 1'b0);
    check("rst_msg", omsg, '0);
    check("rst_src", osrc, '0);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) cycle(1, NP'(1 << (i % NP)), i > 0, SW'((i + 3) % NP));
    for (int i = 0; i < NP; i++) ival[i] = 1'b0;
    cycle(0, '0, 0, '0);
    cycle(0, '0, 0, '0);
    reset = 1'b0;
    cycle(0, '0, 0, '0);
    for (int n = 0; n < 20; n++) begin
      reset = tbl[n].rst;
      ordy  = tbl[n].ordy;
      for (int i = 0; i < NP; i++) ival[i] = tbl[n].val[i];
      cycle(1, tbl[n].erdy, tbl[n].eoval, tbl[n].esrc);
    end
    reset = 1'b1;
    ordy  = 1'b1;
    for (int j = 0; j < 3; j++) begin
      imsg[1] = NB'(32'hA + j);
      ival[1] = 1'b1;
      cycle(1, 4'b0010, j > 0, 2'd1);
    end
    ival[1] = 1'b0;
    cycle(1, 4'b0000, 1'b1, 2'd1);
    cycle(1, 4'b0000, 1'b0, 2'd0);
    for (int n = 0; n < 400; n++) begin
      reset = $urandom_range(0, 49) != 0;
      ordy  = $urandom_range(0, 1) == 1;
      for (int i = 0; i < NP; i++) begin
        ival[i] = $urandom_range(0, 1) == 1;
        imsg[i] = $urandom;
      end
      cycle(0, '0, 0, '0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
